// File: rtl/decoder_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// decoder_pkg: widths, buffer count type and flit-rewrite helper. Rev 1.0
// ----------------------------------------------------------------------------
package decoder_pkg;

  localparam int MAXW = 64;

  typedef logic [1:0] buf_cnt_t;

  function automatic int sel_width(input int nout);
    return (nout > 1) ? $clog2(nout) : 1;
  endfunction

  // Removes the select field and closes the gap; zero-fill lands at the top.
  function automatic logic [MAXW-1:0] fwd_flit(input logic [MAXW-1:0] flit,
                                               input int sel_lsb,
                                               input int selw,
                                               input bit shift_addr);
    logic [MAXW-1:0] lo_mask;
    lo_mask = ~({MAXW{1'b1}} << sel_lsb);
    if (!shift_addr) return flit;
    return ((flit >> (sel_lsb + selw)) << sel_lsb) | (flit & lo_mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_full_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sync_full_buffer: 2-entry valid/ready full buffer, push side driven by count. Rev 1.0
// ----------------------------------------------------------------------------
module sync_full_buffer #(
  parameter int W = 9
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [W-1:0]         push_data_i,
  output decoder_pkg::buf_cnt_t count_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [W-1:0]         out_data_o
);

  decoder_pkg::buf_cnt_t count_q, count_d;
  logic [W-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
  logic         pop;

  always_comb begin
    pop     = (count_q != 2'd0) && out_ready_i;
    count_d = count_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    case ({push_i, pop})
      2'b10: begin
        if (count_q == 2'd0) slot0_d = push_data_i;
        else if (count_q == 2'd1) slot1_d = push_data_i;
        if (count_q != 2'd2) count_d = count_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Count is unchanged; at full the second slot moves up and refills.
        if (count_q == 2'd1) begin
          slot0_d = push_data_i;
        end else begin
          slot0_d = slot1_q;
          slot1_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) count_q <= 2'd0;
    else         count_q <= count_d;
  end

  always_ff @(posedge clk_i) begin
    slot0_q <= slot0_d;
    slot1_q <= slot1_d;
  end

  assign count_o     = count_q;
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = slot0_q;

endmodule
`default_nettype wire

// File: rtl/decoder_leaf_n.sv
`default_nettype none
// ----------------------------------------------------------------------------
// decoder_leaf_n: 1-to-NOUT flit demux leaf with input FIFO and S report. Rev 1.0
// ----------------------------------------------------------------------------
module decoder_leaf_n #(
  parameter int W          = 9,
  parameter int NOUT       = 4,
  parameter int SEL_LSB    = 0,
  parameter int SHIFT_ADDR = 1,
  parameter int DEPTH      = 4
) (
  input  logic                      CLK,
  input  logic                      _RESET,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [W-1:0]              in_data,
  output logic [NOUT-1:0]           out_valid,
  input  logic [NOUT-1:0]           out_ready,
  output logic [NOUT*W-1:0]         out_data,
  output logic                      s_valid,
  input  logic                      s_ready,
  output logic [$clog2(NOUT)-1:0]   s_data,
  output logic                      err_badsel
);
  import decoder_pkg::*;

  localparam int             SELW    = sel_width(NOUT);
  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW:0]    DEPTH_C = DEPTH[AW:0];
  localparam logic [SELW:0]  NOUT_C  = NOUT[SELW:0];

  logic [W-1:0]    mem_q [DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fill_d;
  logic            in_ready_q, err_q, err_d;
  logic            fifo_push, fifo_pop, fifo_empty;
  logic [W-1:0]    head, fwd;
  logic [SELW-1:0] sel;
  logic            bad_sel, tgt_free, s_free, s_push;
  logic [NOUT-1:0] out_push;
  buf_cnt_t        out_cnt [NOUT];
  buf_cnt_t        s_cnt;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign sel        = head[SEL_LSB +: SELW];
  assign bad_sel    = ({1'b0, sel} >= NOUT_C);
  assign fwd        = W'(fwd_flit(MAXW'(head), SEL_LSB, SELW, SHIFT_ADDR != 0));

  always_comb begin
    tgt_free = 1'b0;
    out_push = '0;
    for (int p = 0; p < NOUT; p++) begin
      if (sel == SELW'(p)) tgt_free = (out_cnt[p] != 2'd2);
    end
    s_free    = (s_cnt != 2'd2);
    fifo_push = in_valid && in_ready_q;
    // A bad select is dropped without needing any buffer space.
    fifo_pop  = !fifo_empty && (bad_sel || (tgt_free && s_free));
    s_push    = fifo_pop && !bad_sel;
    for (int p = 0; p < NOUT; p++) begin
      out_push[p] = s_push && (sel == SELW'(p));
    end
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, fifo_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, fifo_pop};
    fill_d   = wr_ptr_d - rd_ptr_d;
    err_d    = err_q || (fifo_pop && bad_sel);
  end

  always_ff @(posedge CLK) begin
    if (!_RESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      in_ready_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      in_ready_q <= (fill_d != DEPTH_C);
      err_q      <= err_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (fifo_push) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
  end

  for (genvar k = 0; k < NOUT; k++) begin : g_out
    sync_full_buffer #(.W(W)) u_obuf (
      .clk_i      (CLK),
      .rst_ni     (_RESET),
      .push_i     (out_push[k]),
      .push_data_i(fwd),
      .count_o    (out_cnt[k]),
      .out_valid_o(out_valid[k]),
      .out_ready_i(out_ready[k]),
      .out_data_o (out_data[k*W +: W])
    );
  end

  sync_full_buffer #(.W(SELW)) u_sbuf (
    .clk_i      (CLK),
    .rst_ni     (_RESET),
    .push_i     (s_push),
    .push_data_i(sel),
    .count_o    (s_cnt),
    .out_valid_o(s_valid),
    .out_ready_i(s_ready),
    .out_data_o (s_data)
  );

  assign in_ready   = in_ready_q;
  assign err_badsel = err_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_leaf_n.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_decoder_leaf_n: directed bench for decoder_leaf_n (NOUT=4 and NOUT=3). Rev 1.0
// ----------------------------------------------------------------------------
module tb_decoder_leaf_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, s_valid, s_ready, err_badsel;
  logic [8:0]  in_data;
  logic [3:0]  out_valid, out_ready;
  logic [35:0] out_data;
  logic [1:0]  s_data;

  logic        in_valid3, in_ready3, s_valid3, s_ready3, err_badsel3;
  logic [8:0]  in_data3;
  logic [2:0]  out_valid3, out_ready3;
  logic [26:0] out_data3;
  logic [1:0]  s_data3;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [8:0] exp_p [4][$];
  logic [1:0] exp_s [$];

  decoder_leaf_n #(.W(9), .NOUT(4), .SEL_LSB(0), .SHIFT_ADDR(1), .DEPTH(4)) u_dut (
    .CLK(clk), ._RESET(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .err_badsel(err_badsel)
  );

  decoder_leaf_n #(.W(9), .NOUT(3), .SEL_LSB(0), .SHIFT_ADDR(1), .DEPTH(4)) u_dut3 (
    .CLK(clk), ._RESET(rst_n), .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .s_valid(s_valid3), .s_ready(s_ready3), .s_data(s_data3), .err_badsel(err_badsel3)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] flit(input int i);
    return 9'((i * i * 37 + i * 101 + 7) & 511);
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b1; in_data = 9'h1A6; in_valid3 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick;
      vec_cnt++;
      if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      vec_cnt++;
      if ({out_valid, s_valid, err_badsel} !== 6'b0) begin
        err_cnt++; $display("FAIL reset_valids: got %b expected 000000", {out_valid, s_valid, err_badsel});
      end
    end
    rst_n = 1'b1; in_valid = 1'b0;
    tick;
    vec_cnt++;
    if ({in_ready, in_ready3} !== 2'b11) begin
      err_cnt++; $display("FAIL release_in_ready: got %b expected 11", {in_ready, in_ready3});
    end
  endtask

  task automatic test_basic;
    out_ready = 4'hF; s_ready = 1'b1;
    in_valid = 1'b1; in_data = 9'h1A6;
    tick;
    in_valid = 1'b0;
    vec_cnt++;
    if (out_valid !== 4'b0000) begin err_cnt++; $display("FAIL basic_early: got %b expected 0000", out_valid); end
    tick;
    vec_cnt++;
    if (out_valid !== 4'b0100) begin err_cnt++; $display("FAIL basic_valid: got %b expected 0100", out_valid); end
    vec_cnt++;
    if (out_data[26:18] !== 9'h069) begin err_cnt++; $display("FAIL basic_data: got %h expected 069", out_data[26:18]); end
    vec_cnt++;
    if ({s_valid, s_data} !== 3'b110) begin err_cnt++; $display("FAIL basic_s: got %b expected 110", {s_valid, s_data}); end
    tick;
    vec_cnt++;
    if ({out_valid, s_valid} !== 5'b0) begin err_cnt++; $display("FAIL basic_drain: got %b expected 00000", {out_valid, s_valid}); end
  endtask

  task automatic test_hol;
    logic [8:0] vec [6];
    logic [8:0] ep;
    logic [1:0] es;
    logic       acc;
    int         idx;
    vec = '{9'h001, 9'h005, 9'h009, 9'h002, 9'h003, 9'h007};
    exp_s = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
    exp_p[1] = '{9'h000, 9'h001, 9'h002};
    exp_p[2] = '{9'h000};
    exp_p[3] = '{9'h000, 9'h001};
    idx = 0; s_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      in_valid  = (idx < 6);
      in_data   = (idx < 6) ? vec[idx] : 9'h000;
      out_ready = (c >= 12) ? 4'hF : 4'b1101;
      if (c == 10) begin
        vec_cnt++;
        if ({in_ready, out_valid, s_valid} !== 6'b0_0010_0) begin
          err_cnt++; $display("FAIL hol_blocked: got %b expected 000100", {in_ready, out_valid, s_valid});
        end
      end
      if (s_valid && s_ready) begin
        vec_cnt++;
        if (exp_s.size() == 0) begin err_cnt++; $display("FAIL hol_s_extra: got %0d expected none", s_data); end
        else begin
          es = exp_s.pop_front();
          if (s_data !== es) begin err_cnt++; $display("FAIL hol_s_order: got %0d expected %0d", s_data, es); end
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          vec_cnt++;
          if (exp_p[k].size() == 0) begin err_cnt++; $display("FAIL hol_port%0d_extra: got %h expected none", k, out_data[k*9 +: 9]); end
          else begin
            ep = exp_p[k].pop_front();
            if (out_data[k*9 +: 9] !== ep) begin err_cnt++; $display("FAIL hol_port%0d_data: got %h expected %h", k, out_data[k*9 +: 9], ep); end
          end
        end
      end
      acc = in_valid && in_ready;
      tick;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    vec_cnt++;
    if (idx + exp_s.size() + exp_p[1].size() + exp_p[2].size() + exp_p[3].size() != 6) begin
      err_cnt++; $display("FAIL hol_leftover: got %0d accepted, %0d undelivered expected 6, 0", idx,
                          exp_s.size() + exp_p[1].size() + exp_p[2].size() + exp_p[3].size());
    end
  endtask

  task automatic test_s_stall;
    logic [8:0] vec [6];
    logic [8:0] ep;
    logic [1:0] es;
    logic       acc;
    int         idx, fired;
    vec = '{9'h0C4, 9'h0F1, 9'h10A, 9'h1FF, 9'h020, 9'h035};
    exp_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp_p[0] = '{9'h031, 9'h008};
    exp_p[1] = '{9'h03C, 9'h00D};
    exp_p[2] = '{9'h042};
    exp_p[3] = '{9'h07F};
    idx = 0; fired = 0; out_ready = 4'hF;
    for (int c = 0; c < 40; c++) begin
      in_valid = (idx < 6);
      in_data  = (idx < 6) ? vec[idx] : 9'h000;
      s_ready  = (c >= 15);
      if (c == 14) begin
        vec_cnt++;
        if (fired != 2 || {in_ready, s_valid, s_data} !== 4'b0100) begin
          err_cnt++; $display("FAIL s_stall_hold: got fired=%0d rdy/sv/sd=%b expected fired=2 0100", fired, {in_ready, s_valid, s_data});
        end
      end
      if (s_valid && s_ready) begin
        vec_cnt++;
        if (exp_s.size() == 0) begin err_cnt++; $display("FAIL s_stall_s_extra: got %0d expected none", s_data); end
        else begin
          es = exp_s.pop_front();
          if (s_data !== es) begin err_cnt++; $display("FAIL s_stall_s_order: got %0d expected %0d", s_data, es); end
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          fired++;
          vec_cnt++;
          if (exp_p[k].size() == 0) begin err_cnt++; $display("FAIL s_stall_port%0d_extra: got %h expected none", k, out_data[k*9 +: 9]); end
          else begin
            ep = exp_p[k].pop_front();
            if (out_data[k*9 +: 9] !== ep) begin err_cnt++; $display("FAIL s_stall_port%0d_data: got %h expected %h", k, out_data[k*9 +: 9], ep); end
          end
        end
      end
      acc = in_valid && in_ready;
      tick;
      if (acc) idx++;
    end
    in_valid = 1'b0; s_ready = 1'b1;
    vec_cnt++;
    if (idx != 6 || fired != 6 || exp_s.size() != 0) begin
      err_cnt++; $display("FAIL s_stall_totals: got acc=%0d out=%0d s_left=%0d expected 6 6 0", idx, fired, exp_s.size());
    end
  endtask

  task automatic test_badsel;
    out_ready3 = 3'b111; s_ready3 = 1'b1;
    vec_cnt++;
    if ({in_ready3, err_badsel3} !== 2'b10) begin err_cnt++; $display("FAIL badsel_pre: got %b expected 10", {in_ready3, err_badsel3}); end
    in_valid3 = 1'b1; in_data3 = 9'h0A3;
    tick;
    in_data3 = 9'h0AC;
    tick;
    in_valid3 = 1'b0;
    vec_cnt++;
    if ({err_badsel3, out_valid3, s_valid3} !== 5'b1_000_0) begin
      err_cnt++; $display("FAIL badsel_drop: got %b expected 10000", {err_badsel3, out_valid3, s_valid3});
    end
    tick;
    vec_cnt++;
    if ({out_valid3, s_valid3, s_data3} !== 6'b001_1_00) begin
      err_cnt++; $display("FAIL badsel_next_route: got %b expected 001100", {out_valid3, s_valid3, s_data3});
    end
    vec_cnt++;
    if (out_data3[8:0] !== 9'h02B) begin err_cnt++; $display("FAIL badsel_next_data: got %h expected 02b", out_data3[8:0]); end
    tick;
    vec_cnt++;
    if ({out_valid3, s_valid3} !== 4'b0) begin err_cnt++; $display("FAIL badsel_s_only0: got %b expected 0000", {out_valid3, s_valid3}); end
    tick; tick; tick;
    vec_cnt++;
    if (err_badsel3 !== 1'b1) begin err_cnt++; $display("FAIL badsel_sticky: got %b expected 1", err_badsel3); end
  endtask

  task automatic test_throughput_reset;
    logic [8:0] e;
    out_ready = 4'hF; s_ready = 1'b1;
    for (int c = 0; c < 51; c++) begin
      rst_n    = (c != 50);
      in_valid = 1'b1;
      in_data  = flit(c);
      if (c >= 2) begin
        e = flit(c - 2);
        vec_cnt++;
        if ({in_ready, s_valid, s_data, out_valid} !== {1'b1, 1'b1, e[1:0], 4'b0001 << e[1:0]} ||
            out_data[e[1:0]*9 +: 9] !== {2'b00, e[8:2]}) begin
          err_cnt++; $display("FAIL tput_flit%0d: got rdy/sv/sd/ov=%b data=%h expected 11%b%b data=%h", c - 2,
                              {in_ready, s_valid, s_data, out_valid}, out_data[e[1:0]*9 +: 9], e[1:0], 4'b0001 << e[1:0], {2'b00, e[8:2]});
        end
      end
      tick;
    end
    vec_cnt++;
    if ({in_ready, out_valid, s_valid} !== 6'b0) begin
      err_cnt++; $display("FAIL tput_reset_clear: got %b expected 000000", {in_ready, out_valid, s_valid});
    end
    rst_n = 1'b1; in_valid = 1'b0;
    tick;
    vec_cnt++;
    if ({in_ready, out_valid, s_valid} !== 6'b1_0000_0) begin
      err_cnt++; $display("FAIL tput_release: got %b expected 100000", {in_ready, out_valid, s_valid});
    end
    for (int c = 0; c < 52; c++) begin
      in_valid = (c < 50);
      in_data  = flit(50 + c);
      if (c >= 2) begin
        e = flit(48 + c);
        vec_cnt++;
        if ({in_ready, s_valid, s_data, out_valid} !== {1'b1, 1'b1, e[1:0], 4'b0001 << e[1:0]} ||
            out_data[e[1:0]*9 +: 9] !== {2'b00, e[8:2]}) begin
          err_cnt++; $display("FAIL tput_post_flit%0d: got rdy/sv/sd/ov=%b data=%h expected 11%b%b data=%h", 48 + c,
                              {in_ready, s_valid, s_data, out_valid}, out_data[e[1:0]*9 +: 9], e[1:0], 4'b0001 << e[1:0], {2'b00, e[8:2]});
        end
      end else begin
        vec_cnt++;
        if ({out_valid, s_valid} !== 5'b0) begin
          err_cnt++; $display("FAIL tput_no_stale: got %b expected 00000", {out_valid, s_valid});
        end
      end
      tick;
    end
    in_valid = 1'b0;
    vec_cnt++;
    if ({out_valid, s_valid} !== 5'b0) begin err_cnt++; $display("FAIL tput_final_idle: got %b expected 00000", {out_valid, s_valid}); end
  endtask

  initial begin
    in_valid = 1'b0; in_data = '0; out_ready = '0; s_ready = 1'b0;
    in_valid3 = 1'b0; in_data3 = '0; out_ready3 = '0; s_ready3 = 1'b0;
    test_reset;
    test_basic;
    test_hol;
    test_s_stall;
    test_badsel;
    test_throughput_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
